sram_msg_reader: RTL

Read-side initiator for the 32x8b message SRAM. On a start pulse it fetches a programmable run of bytes from a base address, wrapping modulo the SRAM depth. It absorbs the SRAM's one-cycle registered read latency and delivers the bytes as a valid/ready stream to the signature datapath. Its SRAM-facing ports connect directly to the SRAM's active-low chip-select and write-select pins and to its read address and data pins.

---
 rtl/sram_rd_pkg.sv | 28 ++
 rtl/msg_byte_fifo.sv | 48 ++++
 rtl/sram_msg_reader.sv | 131 +++++++++++++
 3 files changed

// File: rtl/sram_rd_pkg.sv
// Shared constants and types for the message SRAM read initiator.
package sram_rd_pkg;

  localparam int BLOCK_SIZE_PER_SRAM = 32;
  localparam int BW_SRAM_ADDR        = 5;
  localparam int BW_SRAM_DATA        = 8;
  localparam int BW_LEN              = BW_SRAM_ADDR + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

  // One buffered stream beat: data byte plus end-of-run marker.
  typedef struct packed {
    logic                    last;
    logic [BW_SRAM_DATA-1:0] data;
  } msg_beat_t;

  // Next word address, wrapping at the SRAM depth.
  function automatic logic [BW_SRAM_ADDR-1:0] next_addr(input logic [BW_SRAM_ADDR-1:0] a);
    if (int'(a) == BLOCK_SIZE_PER_SRAM - 1) return '0;
    return a + 1'b1;
  endfunction

endpackage

// File: rtl/msg_byte_fifo.sv
// 2-entry synchronous FIFO holding stream beats between SRAM and consumer.
module msg_byte_fifo
  import sram_rd_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  msg_beat_t push_beat,
  input  logic      pop,
  output msg_beat_t head,
  output logic      empty,
  output logic [1:0] count
);

  msg_beat_t  mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] cnt;
  logic       push_ok;
  logic       pop_ok;

  // A push into a full FIFO is only legal when a pop frees a slot the same cycle.
  assign push_ok = push && ((cnt != 2'd2) || pop);
  assign pop_ok  = pop && (cnt != 2'd0);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_beat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (cnt == 2'd0);
  assign count = cnt;

endmodule

// File: rtl/sram_msg_reader.sv
// Read-side initiator for the 32x8b message SRAM: fetches a wrapped run of
// bytes, hides the one-cycle SRAM read latency and streams them out.
// Optional running XOR of handed-off bytes: define MSG_RD_CHECKSUM_EN.
module sram_msg_reader
  import sram_rd_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BW_SRAM_ADDR-1:0] base_addr,
  input  logic [BW_LEN-1:0]       len,
  output logic                    busy,
  output logic                    done,
  output logic                    sram_csb,
  output logic                    sram_wsb,
  output logic [BW_SRAM_ADDR-1:0] sram_raddr,
  input  logic [BW_SRAM_DATA-1:0] sram_rdata,
  output logic [BW_SRAM_DATA-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic [BW_SRAM_DATA-1:0] checksum
);

  rd_state_e               state_q, next_state;
  logic [BW_SRAM_ADDR-1:0] addr_q;
  logic [BW_LEN-1:0]       remain_q;     // reads still to issue
  logic                    inflight_q;   // read issued last cycle, data on sram_rdata now
  logic                    inflight_last_q;
  logic                    issue;
  logic                    credit_ok;
  logic                    pop;
  logic                    accept;
  msg_beat_t               head;
  logic                    fifo_empty;
  logic [1:0]              fifo_count;

  assign accept = (state_q == IDLE) && start;
  assign pop    = m_valid && m_ready;

  // Next state, read issue and status outputs.
  always_comb begin
    next_state = state_q;
    busy       = 1'b0;
    done       = 1'b0;
    issue      = 1'b0;
    // Buffered + inflight after this cycle's pop must leave room for one more byte.
    credit_ok  = ({1'b0, fifo_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    case (state_q)
      IDLE: begin
        if (start) next_state = (len == '0) ? DONE : FETCH;
      end
      FETCH: begin
        busy  = 1'b1;
        issue = (remain_q != '0) && credit_ok;
        if (issue && (remain_q == BW_LEN'(1))) next_state = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (pop && head.last) next_state = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= next_state;
  end

  // Address counter, remaining count and the one-deep inflight tracker.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q          <= '0;
      remain_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q   <= base_addr;
        remain_q <= len;
      end else if (issue) begin
        addr_q   <= next_addr(addr_q);
        remain_q <= remain_q - 1'b1;
      end
      inflight_q      <= issue;
      inflight_last_q <= issue && (remain_q == BW_LEN'(1));
    end
  end

  msg_byte_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_beat ({inflight_last_q, sram_rdata}),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign sram_csb   = ~issue;
  assign sram_wsb   = 1'b1;
  assign sram_raddr = addr_q;
  assign m_valid    = ~fifo_empty;
  // Stale FIFO contents are masked so idle outputs read as zero.
  assign m_data     = m_valid ? head.data : '0;
  assign m_last     = m_valid & head.last;

`ifdef MSG_RD_CHECKSUM_EN
  logic [BW_SRAM_DATA-1:0] ck_q;

  // Running XOR of bytes handed off in the current run.
  always_ff @(posedge clk) begin
    if (rst)         ck_q <= '0;
    else if (accept) ck_q <= '0;
    else if (pop)    ck_q <= ck_q ^ head.data;
  end

  assign checksum = ck_q;
`else
  assign checksum = '0;
`endif

endmodule
